// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared pb_word field layout and default parameters
package pb_pkg;

  localparam int PB_WORD_W               = 32;
  localparam int LEVEL_LSB               = 0;
  localparam int LEVEL_W                 = 8;
  localparam int CNT_LSB                 = 8;
  localparam int CNT_W                   = 4;
  localparam int CNT_FIELDS              = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int SW_W                    = 16;

endpackage

// File: rtl/pb_debounce_ch.sv
// rtl/pb_debounce_ch.sv - one button: synchronizer, debounce, stable level, press counter
module pb_debounce_ch
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_n_raw,
  output logic             stable,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0]       press_cnt_q, press_cnt_d;
  logic                   level;

  // Shift the raw key through the synchronizer; debounce the pressed level
  // and count a press one cycle after the stable level rises.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], key_n_raw};
    level        = ~sync_q[SYNC_STAGES-1];
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    stable_dly_d = stable_q;
    press_cnt_d  = press_cnt_q;
    if (level == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      stable_d = level;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (stable_q && !stable_dly_q) begin
      press_cnt_d = press_cnt_q + 1'b1;
    end
  end

  // State registers; synchronizer resets to released so reset release is silent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '1;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_cnt_q  <= '0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_cnt_q  <= press_cnt_d;
    end
  end

  assign stable    = stable_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: rtl/pb_conditioner.sv
// rtl/pb_conditioner.sv - push-button debounce/press-count status word and switch synchronizer
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_BTN-1:0]     key_n_raw,
  input  logic [SW_W-1:0]      sw_raw,
  output logic [PB_WORD_W-1:0] pb_word,
  output logic [SW_W-1:0]      sw_sync
);

  logic [N_BTN-1:0]                  stable_vec;
  logic [N_BTN-1:0][CNT_W-1:0]       press_cnt_arr;
  logic [LEVEL_W-1:0]                level_bits;
  logic [CNT_FIELDS-1:0][CNT_W-1:0]  cnt_fields;
  logic [SYNC_STAGES-1:0][SW_W-1:0]  sw_sync_q, sw_sync_d;
  logic [PB_WORD_W-1:0]              word;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    pb_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_n_raw (key_n_raw[i]),
      .stable    (stable_vec[i]),
      .press_cnt (press_cnt_arr[i])
    );
  end

  for (genvar i = 0; i < LEVEL_W; i++) begin : g_lvl
    if (i < N_BTN) begin : g_on
      assign level_bits[i] = stable_vec[i];
    end else begin : g_off
      assign level_bits[i] = 1'b0;
    end
  end

  for (genvar i = 0; i < CNT_FIELDS; i++) begin : g_cnt
    if (i < N_BTN) begin : g_on
      assign cnt_fields[i] = press_cnt_arr[i];
    end else begin : g_off
      assign cnt_fields[i] = '0;
    end
  end

  // Pack flop outputs into the status word; unused fields read as zero.
  always_comb begin
    word                            = '0;
    word[LEVEL_LSB +: LEVEL_W]      = level_bits;
    word[CNT_LSB +: CNT_FIELDS*CNT_W] = cnt_fields;
  end

  // Next value of the switch synchronizer chain.
  always_comb begin
    sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], sw_raw};
  end

  // Switch synchronizer flops, cleared on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_sync_q <= '0;
    end else begin
      sw_sync_q <= sw_sync_d;
    end
  end

  assign pb_word = word;
  assign sw_sync = sw_sync_q[SYNC_STAGES-1];

endmodule

// File: doc/pb_conditioner.md
PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 Parameter N_BTN, default 4: number of push buttons conditioned.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: stable-input cycles required to accept a change (10 ms at 50 MHz); legal range 2..2^20.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth; legal range 2..3.
REQ-004 Port clk, input, 1: single clock, all flops on rising edge.
REQ-005 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port key_n_raw, input, N_BTN: raw asynchronous board buttons, 0 = pressed.
REQ-007 Port sw_raw, input, 16: raw asynchronous slide switches.
REQ-008 Port pb_word, output, 32: status word driven into push_buttons_external_connection_export.
REQ-009 Port sw_sync, output, 16: synchronized switches driven into inport_external_connection_export.

Function
REQ-010 Each key_n_raw bit and each sw_raw bit SHALL pass through a SYNC_STAGES-deep flop chain before any other use.
REQ-011 sw_sync SHALL equal the last synchronizer stage of sw_raw, with no debounce applied.
REQ-012 Each button SHALL hold a debounced level `stable`, 1 = pressed (inverted from key_n_raw), and a counter `cnt` of width clog2(DEBOUNCE_CYCLES).
REQ-013 When synced pressed-level equals stable, cnt SHALL load 0 on that edge.
REQ-014 When they differ and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment.
REQ-015 When they differ and cnt == DEBOUNCE_CYCLES-1, stable SHALL take the synced value and cnt SHALL load 0.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL never change stable; any return to equality restarts the count from 0.
REQ-017 Latency: a raw change first sampled at edge 1 and held SHALL change stable at edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-018 Each button SHALL have a 4-bit press counter that increments, modulo 16 (15 -> 0), one edge after stable goes 0 -> 1.
REQ-019 A release (stable 1 -> 0) SHALL NOT change the press counter.
REQ-020 Buttons SHALL be fully independent; simultaneous transitions on several buttons SHALL each be processed in the same cycle.
REQ-021 pb_word[N_BTN-1:0] SHALL equal the stable vector, and pb_word[7:N_BTN] SHALL be 0.
REQ-022 pb_word[8+4i+3 : 8+4i] SHALL carry the press counter of button i, for i < 4.
REQ-023 Counter fields for i >= N_BTN, and pb_word[31:24], SHALL be 0.
REQ-024 pb_word and sw_sync SHALL be driven directly from flops, with no combinational path from inputs.
REQ-025 Software detects presses by counter change; no clear handshake exists, and up to 15 unread presses per button are distinguishable.

Reset
REQ-026 Asserting reset_n low SHALL immediately clear stable, cnt, press counters and pb_word to 0, and sw_sync to 0.
REQ-027 Button synchronizer flops SHALL reset to 1 (released), so no press event is generated at reset release.
REQ-028 Switch synchronizer flops SHALL reset to 0.
REQ-029 Reset asserted mid-debounce SHALL discard the partial count; after release, debounce restarts from cnt = 0.

Structure
REQ-030 Package pb_pkg SHALL hold the pb_word field offsets (LEVEL_LSB = 0, CNT_LSB = 8, CNT_W = 4) and the default DEBOUNCE_CYCLES.
REQ-031 One sub-module, pb_debounce_ch, SHALL implement the per-button synchronizer, debounce counter, stable level and press counter, instantiated N_BTN times.
REQ-032 Target size is 120-400 RTL lines total.

Verification (DEBOUNCE_CYCLES = 8, SYNC_STAGES = 2)
REQ-033 Scenario 1: key_n_raw[0] driven 1 -> 0 and held -> pb_word[0] = 1 at edge 10 and pb_word[11:8] = 1 at edge 11; other bits stay 0.
REQ-034 Scenario 2: key_n_raw[1] pulsed low for 7 synced cycles, then high -> pb_word stays 0x00000000.
REQ-035 Scenario 3: 17 clean press/release cycles on button 2 -> pb_word[19:16] = 1 (wrap), with pb_word[2] tracking each press.
REQ-036 Scenario 4: all four buttons pressed on the same edge -> pb_word = 0x0011110F after settle.
REQ-037 Scenario 5: reset_n asserted with button 3 held and count at 5, then released with button still held -> pb_word = 0 during reset; pb_word[3] = 1 exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after release; counter field = 1.
REQ-038 Scenario 6: sw_raw = 0xA5C3 -> sw_sync = 0xA5C3 two edges later, unaffected by button activity.
